sdram_timing_ctrl: RTL and testbench

SDRAM_TIMING_CTRL -- requirements
Module: sdram_timing_ctrl

---
 rtl/sdram_pkg.sv | 30 +++
 rtl/sdram_phase_counter.sv | 29 ++
 rtl/sdram_timing_ctrl.sv | 161 ++++++++++++++++
 tb/tb_sdram_timing_ctrl.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sdram_pkg.sv
// Shared encodings for the SDRAM timing controller: FSM states, command strobes,
// timing width and the column-order helper.
package sdram_pkg;

  localparam int TIMING_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_CAS_WAIT  = 3'd1,
    ST_LATENCY   = 3'd2,
    ST_BURST     = 3'd3,
    ST_WAIT      = 3'd4,
    ST_PRECHARGE = 3'd5
  } state_t;

  // Strobe patterns as {CS, RAS, CAS}, all active-low.
  localparam logic [2:0] CMD_ACTIVATE = 3'b001;
  localparam logic [2:0] CMD_PROGRAM  = 3'b000;

  // A phase of N cycles loads N-1; zero still gives a one-cycle phase.
  function automatic logic [TIMING_W-1:0] phase_load(input logic [TIMING_W-1:0] n);
    return (n == '0) ? '0 : n - 8'd1;
  endfunction

  function automatic logic [7:0] beat_col(input logic [7:0] start, input logic [7:0] beat,
                                          input logic interleaved);
    return interleaved ? (start ^ beat) : (start + beat);
  endfunction

endpackage

// File: rtl/sdram_phase_counter.sv
// Loadable down-counter timing every phase of the SDRAM controller FSM;
// holds at zero until the next load.
module sdram_phase_counter
  import sdram_pkg::*;
(
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_load,
  input  logic [TIMING_W-1:0] i_load_val,
  output logic [TIMING_W-1:0] o_count,
  output logic                o_zero
);

  logic [TIMING_W-1:0] r_count;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (r_count != '0) begin
      r_count <= r_count - 8'd1;
    end
  end

  assign o_count = r_count;
  assign o_zero  = (r_count == '0);

endmodule

// File: rtl/sdram_timing_ctrl.sv
// SDRAM command timing controller: activate -> CAS wait -> (read latency) -> burst
// -> wait -> precharge. Define SDRAM_BURST_ABORT_EN to let CS=1 cut a burst short.
module sdram_timing_ctrl
  import sdram_pkg::*;
(
  input  logic        Clk,
  input  logic        Rst,
  input  logic        CS,
  input  logic        RAS,
  input  logic        CAS,
  input  logic        WeIn,
  input  logic [31:0] AddrIn,
  input  logic [7:0]  tburst,
  input  logic [7:0]  tcas,
  input  logic [7:0]  twait,
  input  logic [7:0]  tpre,
  input  logic [3:0]  tlat,
  input  logic        addr_mode,
  output logic        Ready,
  output logic        DataEn,
  output logic [7:0]  ColAddr,
  output logic [7:0]  BeatCnt,
  output logic [2:0]  Phase,
  output logic        Done
);

  state_t              r_state;
  logic                r_we;
  logic                r_mode;
  logic [7:0]          r_start;
  logic [TIMING_W-1:0] r_tburst, r_twait, r_tpre;
  logic [3:0]          r_tlat;
  logic                r_ready, r_data_en, r_done;
  logic [7:0]          r_col, r_beat;

  state_t              w_next;
  logic                w_load;
  logic [TIMING_W-1:0] w_load_val;
  logic [TIMING_W-1:0] w_count;
  logic                w_zero;
  logic                w_activate;
  logic                w_abort;
  logic [7:0]          w_beat_inc;
  logic                w_unused_addr;

  assign w_activate    = (r_state == ST_IDLE) && ({CS, RAS, CAS} == CMD_ACTIVATE);
  assign w_beat_inc    = r_beat + 8'd1;
  assign w_unused_addr = ^AddrIn[31:8];

`ifdef SDRAM_BURST_ABORT_EN
  assign w_abort = CS;
`else
  assign w_abort = 1'b0;
`endif

  sdram_phase_counter u_phase_cnt (
    .i_clk      (Clk),
    .i_rst      (Rst),
    .i_load     (w_load),
    .i_load_val (w_load_val),
    .o_count    (w_count),
    .o_zero     (w_zero)
  );

  // Next state and the counter reload for the phase being entered.
  always_comb begin
    w_next     = r_state;
    w_load     = 1'b0;
    w_load_val = '0;
    case (r_state)
      ST_IDLE: if (w_activate) begin
        w_next     = ST_CAS_WAIT;
        w_load     = 1'b1;
        w_load_val = phase_load(tcas);
      end
      ST_CAS_WAIT: if (w_zero) begin
        w_next     = r_we ? ST_BURST : ST_LATENCY;
        w_load     = 1'b1;
        w_load_val = r_we ? phase_load(r_tburst) : phase_load({4'd0, r_tlat});
      end
      ST_LATENCY: if (w_zero) begin
        w_next     = ST_BURST;
        w_load     = 1'b1;
        w_load_val = phase_load(r_tburst);
      end
      ST_BURST: if (w_abort) begin
        w_next     = ST_PRECHARGE;
        w_load     = 1'b1;
        w_load_val = phase_load(r_tpre);
      end else if (w_zero) begin
        w_next     = ST_WAIT;
        w_load     = 1'b1;
        w_load_val = phase_load(r_twait);
      end
      ST_WAIT: if (w_zero) begin
        w_next     = ST_PRECHARGE;
        w_load     = 1'b1;
        w_load_val = phase_load(r_tpre);
      end
      ST_PRECHARGE: if (w_zero) begin
        w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      r_state   <= ST_IDLE;
      r_we      <= 1'b0;
      r_mode    <= 1'b0;
      r_start   <= '0;
      r_tburst  <= '0;
      r_twait   <= '0;
      r_tpre    <= '0;
      r_tlat    <= '0;
      r_ready   <= 1'b1;
      r_data_en <= 1'b0;
      r_done    <= 1'b0;
      r_col     <= '0;
      r_beat    <= '0;
    end else begin
      r_state   <= w_next;
      r_ready   <= (w_next == ST_IDLE);
      r_data_en <= (w_next == ST_BURST);
      if (w_activate) begin
        r_we     <= WeIn;
        r_mode   <= addr_mode;
        r_start  <= AddrIn[7:0];
        r_tburst <= tburst;
        r_twait  <= twait;
        r_tpre   <= tpre;
        r_tlat   <= tlat;
      end
      // Done is registered one cycle ahead so it lines up with the last precharge cycle.
      if (w_load && (w_next == ST_PRECHARGE)) begin
        r_done <= (w_load_val == '0);
      end else begin
        r_done <= (r_state == ST_PRECHARGE) && (w_count == 8'd1);
      end
      if ((w_next == ST_BURST) && (r_state == ST_BURST)) begin
        r_beat <= w_beat_inc;
        r_col  <= beat_col(r_start, w_beat_inc, r_mode);
      end else if (w_next == ST_BURST) begin
        r_beat <= '0;
        r_col  <= r_start;
      end else begin
        r_beat <= '0;
        r_col  <= w_activate ? AddrIn[7:0] : r_start;
      end
    end
  end

  assign Ready   = r_ready;
  assign DataEn  = r_data_en;
  assign ColAddr = r_col;
  assign BeatCnt = r_beat;
  assign Phase   = r_state;
  assign Done    = r_done;

endmodule

// File: tb/tb_sdram_timing_ctrl.sv
// Bench for sdram_timing_ctrl: a transaction-level model expands each activate into
// its expected per-cycle output sequence; directed cases pin that model to literals.
module tb_sdram_timing_ctrl;
  import sdram_pkg::*;

  logic        Clk = 1'b0;
  logic        Rst = 1'b1;
  logic        CS = 1'b1, RAS = 1'b1, CAS = 1'b1;
  logic        WeIn = 1'b0;
  logic [31:0] AddrIn = '0;
  logic [7:0]  tburst = '0, tcas = '0, twait = '0, tpre = '0;
  logic [3:0]  tlat = '0;
  logic        addr_mode = 1'b0;
  logic        Ready, DataEn, Done;
  logic [7:0]  ColAddr, BeatCnt;
  logic [2:0]  Phase;

  sdram_timing_ctrl dut (
    .Clk(Clk), .Rst(Rst), .CS(CS), .RAS(RAS), .CAS(CAS), .WeIn(WeIn), .AddrIn(AddrIn),
    .tburst(tburst), .tcas(tcas), .twait(twait), .tpre(tpre), .tlat(tlat),
    .addr_mode(addr_mode), .Ready(Ready), .DataEn(DataEn), .ColAddr(ColAddr),
    .BeatCnt(BeatCnt), .Phase(Phase), .Done(Done)
  );

  // ---------------- clock ----------------
  always #5 Clk = ~Clk;

  // ---------------- reference model ----------------
  typedef struct packed {
    logic       ready;
    logic       den;
    logic [7:0] col;
    logic [7:0] beat;
    logic [2:0] phase;
    logic       done;
  } exp_t;

  exp_t       exp_q[$];
  exp_t       cur;
  logic [7:0] last_start = '0;
  int         txn_abort = -1;
  int         n_vec = 0;
  int         n_bad = 0;

  function automatic exp_t mk(input logic den, input logic [7:0] col, input logic [7:0] beat,
                              input logic [2:0] phase, input logic done);
    exp_t e;
    e.ready = (phase == ST_IDLE);
    e.den   = den;
    e.col   = col;
    e.beat  = beat;
    e.phase = phase;
    e.done  = done;
    return e;
  endfunction

  function automatic int len(input int n);
    return (n < 1) ? 1 : n;
  endfunction

  // Expand one activate (inputs as sampled now) into its full cycle sequence.
  task automatic build_txn();
    int lc = len(int'(tcas));
    int ll = WeIn ? 0 : len(int'(tlat));
    int lb = len(int'(tburst));
    int lw = len(int'(twait));
    int lp = len(int'(tpre));
    logic [7:0] s = AddrIn[7:0];
    logic       md = addr_mode;
    bit aborted = 0;
    logic [7:0] kb, c;
    for (int i = 0; i < lc; i++) exp_q.push_back(mk(1'b0, s, 8'd0, ST_CAS_WAIT, 1'b0));
    for (int i = 0; i < ll; i++) exp_q.push_back(mk(1'b0, s, 8'd0, ST_LATENCY, 1'b0));
    for (int k = 0; k < lb; k++) begin
      kb = 8'(k);
      c  = md ? (s ^ kb) : 8'(s + kb);
      exp_q.push_back(mk(1'b1, c, kb, ST_BURST, 1'b0));
`ifdef SDRAM_BURST_ABORT_EN
      if (k == txn_abort) begin
        aborted = 1;
        break;
      end
`endif
    end
    if (!aborted)
      for (int i = 0; i < lw; i++) exp_q.push_back(mk(1'b0, s, 8'd0, ST_WAIT, 1'b0));
    for (int i = 0; i < lp; i++) exp_q.push_back(mk(1'b0, s, 8'd0, ST_PRECHARGE, i == lp - 1));
  endtask

  initial cur = mk(1'b0, 8'd0, 8'd0, ST_IDLE, 1'b0);

  always @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      exp_q.delete();
      last_start = '0;
      cur = mk(1'b0, 8'd0, 8'd0, ST_IDLE, 1'b0);
    end else if (exp_q.size() > 0) begin
      cur = exp_q.pop_front();
    end else if (cur.phase == ST_IDLE && {CS, RAS, CAS} == 3'b001) begin
      last_start = AddrIn[7:0];
      build_txn();
      cur = exp_q.pop_front();
    end else begin
      cur = mk(1'b0, last_start, 8'd0, ST_IDLE, 1'b0);
    end
  end

  // ---------------- scoreboard compare ----------------
  always @(negedge Clk) begin
    n_vec++;
    if ({Ready, DataEn, ColAddr, BeatCnt, Phase, Done} !== cur) begin
      n_bad++;
      $display("FAIL cycle @%0t: got rdy=%b en=%b col=%h beat=%0d ph=%0d done=%b, want rdy=%b en=%b col=%h beat=%0d ph=%0d done=%b",
               $time, Ready, DataEn, ColAddr, BeatCnt, Phase, Done,
               cur.ready, cur.den, cur.col, cur.beat, cur.phase, cur.done);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  int         cnt_ph[8];
  logic [7:0] cap_cols[$];
  int         n_done;
  logic       last_done;

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic drive_idle(input int n);
    for (int i = 0; i < n; i++) begin
      case ($urandom_range(0, 3))
        0:       {CS, RAS, CAS} = CMD_PROGRAM;
        1:       {CS, RAS, CAS} = 3'b111;
        2:       {CS, RAS, CAS} = 3'b010;
        default: {CS, RAS, CAS} = 3'b101;
      endcase
      tcas = 8'($urandom());
      tburst = 8'($urandom());
      step();
    end
    {CS, RAS, CAS} = 3'b111;
  endtask

  task automatic do_txn(input logic we, input logic [7:0] start, input logic mode,
                        input logic [7:0] c, input logic [3:0] l, input logic [7:0] b,
                        input logic [7:0] w, input logic [7:0] p,
                        input int abort_beat, input int rst_beat);
    for (int i = 0; i < 8; i++) cnt_ph[i] = 0;
    cap_cols.delete();
    n_done = 0;
    last_done = 1'b0;
    txn_abort = abort_beat;
    {CS, RAS, CAS} = 3'b001;
    WeIn = we; AddrIn = {24'($urandom()), start}; addr_mode = mode;
    tcas = c; tlat = l; tburst = b; twait = w; tpre = p;
    step();
    for (int cyc = 0; cyc < 2000 && cur.phase != ST_IDLE; cyc++) begin
      cnt_ph[Phase]++;
      if (DataEn) cap_cols.push_back(ColAddr);
      if (Done) n_done++;
      last_done = Done;
      if (rst_beat >= 0 && cur.phase == ST_BURST && cur.beat == 8'(rst_beat)) begin
        #2 Rst = 1'b1;
        #1;
        check("async_reset_outputs", {10'd0, Ready, DataEn, ColAddr, BeatCnt, Phase, Done},
              {10'd0, 1'b1, 1'b0, 8'h00, 8'h00, 3'(ST_IDLE), 1'b0});
        step();
        Rst = 1'b0;
        return;
      end
      RAS = 1'($urandom()); CAS = 1'($urandom());
`ifdef SDRAM_BURST_ABORT_EN
      CS = (cur.phase == ST_BURST && cur.beat == 8'(abort_beat));
`else
      CS = 1'($urandom());
`endif
      WeIn = 1'($urandom()); AddrIn = $urandom(); addr_mode = 1'($urandom());
      tcas = 8'($urandom()); tlat = 4'($urandom()); tburst = 8'($urandom());
      twait = 8'($urandom()); tpre = 8'($urandom());
      step();
    end
    {CS, RAS, CAS} = 3'b111;
  endtask

  task automatic check_cols(input string name, input logic [31:0] exp4);
    logic [31:0] act;
    act = {cap_cols.size() > 0 ? cap_cols[0] : 8'hxx, cap_cols.size() > 1 ? cap_cols[1] : 8'hxx,
           cap_cols.size() > 2 ? cap_cols[2] : 8'hxx, cap_cols.size() > 3 ? cap_cols[3] : 8'hxx};
    check({name, "_count"}, cap_cols.size(), 4);
    check(name, act, exp4);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    repeat (2) @(posedge Clk);
    #1;
    check("reset_outputs", {10'd0, Ready, DataEn, ColAddr, BeatCnt, Phase, Done},
          {10'd0, 1'b1, 1'b0, 8'h00, 8'h00, 3'(ST_IDLE), 1'b0});
    Rst = 1'b0;
    step();

    // Write, tcas=2 tburst=4 twait=1 tpre=3, start 0x10 sequential.
    do_txn(1'b1, 8'h10, 1'b0, 8'd2, 4'd0, 8'd4, 8'd1, 8'd3, -1, -1);
    check("wr_cas_cycles", cnt_ph[ST_CAS_WAIT], 2);
    check("wr_lat_cycles", cnt_ph[ST_LATENCY], 0);
    check_cols("wr_cols", 32'h10111213);
    check("wr_wait_cycles", cnt_ph[ST_WAIT], 1);
    check("wr_pre_cycles", cnt_ph[ST_PRECHARGE], 3);
    check("wr_done_once", n_done, 1);
    check("wr_done_last_pre", last_done, 1);
    check("wr_ready_after", Ready, 1);
    drive_idle(2);

    // Read, tcas=1 tlat=3 tburst=2.
    do_txn(1'b0, 8'h80, 1'b0, 8'd1, 4'd3, 8'd2, 8'd1, 8'd1, -1, -1);
    check("rd_cas_cycles", cnt_ph[ST_CAS_WAIT], 1);
    check("rd_lat_cycles", cnt_ph[ST_LATENCY], 3);
    check("rd_burst_beats", cap_cols.size(), 2);
    drive_idle(1);

    do_txn(1'b1, 8'h05, 1'b1, 8'd1, 4'd0, 8'd4, 8'd1, 8'd1, -1, -1);
    check_cols("interleave_cols", 32'h05040706);
    do_txn(1'b1, 8'hFE, 1'b0, 8'd1, 4'd0, 8'd4, 8'd1, 8'd1, -1, -1);
    check_cols("wrap_cols", 32'hFEFF0001);

    // Program command in IDLE is ignored.
    {CS, RAS, CAS} = CMD_PROGRAM;
    repeat (3) step();
    check("program_ignored", {Ready, Phase}, {1'b1, 3'(ST_IDLE)});
    {CS, RAS, CAS} = 3'b111;
    step();

    // Zero timing values still give one-cycle phases.
    do_txn(1'b1, 8'h33, 1'b0, 8'd0, 4'd0, 8'd1, 8'd0, 8'd0, -1, -1);
    check("tcas0_cas_cycles", cnt_ph[ST_CAS_WAIT], 1);
    check("twait0_wait_cycles", cnt_ph[ST_WAIT], 1);
    check("tpre0_pre_cycles", cnt_ph[ST_PRECHARGE], 1);

    // Reset at beat 2, then the first activate must be honoured.
    do_txn(1'b1, 8'h40, 1'b0, 8'd1, 4'd0, 8'd6, 8'd1, 8'd1, -1, 2);
    do_txn(1'b1, 8'h22, 1'b0, 8'd1, 4'd0, 8'd3, 8'd1, 8'd1, -1, -1);
    check("post_reset_beats", cap_cols.size(), 3);

`ifdef SDRAM_BURST_ABORT_EN
    do_txn(1'b1, 8'h30, 1'b0, 8'd1, 4'd0, 8'd8, 8'd2, 8'd2, 3, -1);
    check("abort_beats", cap_cols.size(), 4);
    check("abort_no_wait", cnt_ph[ST_WAIT], 0);
    check("abort_pre_cycles", cnt_ph[ST_PRECHARGE], 2);
`else
    do_txn(1'b1, 8'h30, 1'b0, 8'd1, 4'd0, 8'd8, 8'd2, 8'd2, 3, -1);
    check("no_abort_beats", cap_cols.size(), 8);
    check("no_abort_wait", cnt_ph[ST_WAIT], 2);
`endif

    for (int t = 0; t < 150; t++) begin
      do_txn(1'($urandom()), 8'($urandom()), 1'($urandom()),
             8'($urandom_range(0, 3)), 4'($urandom_range(0, 5)), 8'($urandom_range(0, 10)),
             8'($urandom_range(0, 3)), 8'($urandom_range(0, 3)),
             int'($urandom_range(0, 12)), -1);
      drive_idle($urandom_range(0, 3));
    end

    step();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    n_bad++;
    $display("FAIL watchdog: got timeout want completion");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
